// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//
// Turns one raw asynchronous input (push-button or switch) into a clean,
// registered level plus single-cycle edge strobes in the clk domain.
//
// The input first passes through a 2-flop synchronizer. A 4-state debounce FSM
// then watches the synchronized value. It accepts a new level only after the
// value has held for STABLE_CYCLES consecutive clocks. Every output is
// registered.
//
// Optional feature (compile-time macro DEBOUNCE_TOGGLE_EN):
//   When defined, the block adds a toggle_out port and its register.
//   toggle_out inverts once per accepted press.
//   When undefined, neither the port nor the register exists.
//
// Parameters:
//   STABLE_CYCLES  consecutive clocks a new level must hold (legal >= 2)
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   rst         in   asynchronous, active-high reset
//   din         in   raw input, asynchronous to clk, may bounce
//   db_out      out  debounced level (registered)
//   rise_pulse  out  1-cycle strobe when db_out goes 0->1
//   fall_pulse  out  1-cycle strobe when db_out goes 1->0
//   toggle_out  out  press-toggled level (only with DEBOUNCE_TOGGLE_EN)
// -----------------------------------------------------------------------------
module debounce_sync #(
  parameter int STABLE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic db_out,
  output logic rise_pulse,
  output logic fall_pulse
`ifdef DEBOUNCE_TOGGLE_EN
  ,
  output logic toggle_out
`endif
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } state_t;

  logic             r_s0;
  logic             r_s1;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_db;
  logic             r_rise;
  logic             r_fall;
`ifdef DEBOUNCE_TOGGLE_EN
  logic             r_tog;
`endif

  // 2-flop synchronizer. Only r_s1 is allowed to feed the FSM.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value; a blocking '=' here would collapse s0/s1 into one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      r_s0 <= din;
      r_s1 <= r_s0;
    end
  end

  // Debounce FSM with registered outputs. The counter is only meaningful in
  // the WAIT states. It is held at 0 elsewhere and restarts on every bounce.
  // It leaves the WAIT state when it reaches CNT_MAX, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_db    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
`ifdef DEBOUNCE_TOGGLE_EN
      r_tog   <= 1'b0;
`endif
    end else begin
      // Strobes default low, so each lasts exactly one cycle.
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        STABLE_LO: begin
          r_db  <= 1'b0;
          r_cnt <= '0;
          if (r_s1) r_state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (!r_s1) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
            r_db    <= 1'b1;
            r_rise  <= 1'b1;
`ifdef DEBOUNCE_TOGGLE_EN
            r_tog   <= ~r_tog;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STABLE_HI: begin
          r_db  <= 1'b1;
          r_cnt <= '0;
          if (!r_s1) r_state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (r_s1) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_fall  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // Any corrupted encoding returns quietly to the safe low state.
        default: begin
          r_state <= STABLE_LO;
          r_cnt   <= '0;
          r_db    <= 1'b0;
        end
      endcase
    end
  end

  assign db_out     = r_db;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
`ifdef DEBOUNCE_TOGGLE_EN
  assign toggle_out = r_tog;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
module tb_debounce_sync;

  localparam int STABLE_CYCLES = 4;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic db_out;
  logic rise_pulse;
  logic fall_pulse;
`ifdef DEBOUNCE_TOGGLE_EN
  logic toggle_out;
`endif

  int n_checks = 0;
  int n_errors = 0;

  debounce_sync #(.STABLE_CYCLES(STABLE_CYCLES)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .db_out     (db_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    .toggle_out (toggle_out)
`endif
  );

  always #5 clk = ~clk;

  // One vector = inputs for one clock plus expected {db_out, rise, fall}
  // sampled 1 time unit after the following posedge.
  typedef struct {
    logic       rst;
    logic       din;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic d, input logic [2:0] e, input int n);
    vec_t v;
    v.rst = r;
    v.din = d;
    v.exp = e;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive inputs at negedge, then sample just after the next posedge.
  task automatic apply(input logic r, input logic d);
    @(negedge clk);
    rst = r;
    din = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] outs();
    return {db_out, rise_pulse, fall_pulse};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    din = 1'b0;

    // Reset with din high, then acceptance at edge 7 after release.
    add(1, 1, 3'b000, 3);
    add(0, 1, 3'b000, 6);
    add(0, 1, 3'b110, 1);
    add(0, 1, 3'b100, 1);
    // Held low: falls at edge 7 with a single fall strobe.
    add(0, 0, 3'b100, 6);
    add(0, 0, 3'b001, 1);
    add(0, 0, 3'b000, 1);
    // Three cycles high then low: rejected as a bounce.
    add(0, 1, 3'b000, 3);
    add(0, 0, 3'b000, 6);
    // 1,0,1,0 bounce then held 1: accepted 7 edges after the last rise.
    add(0, 1, 3'b000, 1);
    add(0, 0, 3'b000, 1);
    add(0, 1, 3'b000, 1);
    add(0, 0, 3'b000, 1);
    add(0, 1, 3'b000, 6);
    add(0, 1, 3'b110, 1);
    add(0, 1, 3'b100, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].din);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Asynchronous reset in the middle of WAIT_HI.
    apply(1, 0);
    apply(0, 1);
    for (int e = 2; e <= 4; e++) apply(0, 1);
    #2 rst = 1'b1;
    #1 check("async_rst_wait_hi_now", outs(), 3'b000);
    apply(1, 1);
    check("async_rst_wait_hi_held", outs(), 3'b000);
    for (int e = 1; e <= 6; e++) begin
      apply(0, 1);
      check($sformatf("requal_edge%0d", e), outs(), 3'b000);
    end
    apply(0, 1);
    check("requal_edge7", outs(), 3'b110);
    apply(0, 1);
    check("requal_edge8", outs(), 3'b100);

    // Asynchronous reset in the middle of WAIT_LO: db_out drops at once.
    for (int e = 1; e <= 4; e++) apply(0, 0);
    check("wait_lo_still_high", outs(), 3'b100);
    #2 rst = 1'b1;
    #1 check("async_rst_wait_lo_now", outs(), 3'b000);
    apply(1, 0);
    for (int e = 1; e <= 8; e++) begin
      apply(0, 0);
      check($sformatf("post_rst_low_edge%0d", e), outs(), 3'b000);
    end

`ifdef DEBOUNCE_TOGGLE_EN
    begin
      logic exp_tog;
      exp_tog = 1'b0;
      apply(1, 0);
      apply(0, 0);
      check("toggle_reset", {2'b00, toggle_out}, {2'b00, exp_tog});
      for (int p = 0; p < 3; p++) begin
        for (int e = 1; e <= 6; e++) apply(0, 1);
        check($sformatf("toggle_press%0d_before", p), {2'b00, toggle_out}, {2'b00, exp_tog});
        apply(0, 1);
        exp_tog = ~exp_tog;
        check($sformatf("toggle_press%0d_accept", p), {rise_pulse, 1'b0, toggle_out}, {1'b1, 1'b0, exp_tog});
        for (int e = 1; e <= 8; e++) apply(0, 0);
        check($sformatf("toggle_press%0d_release", p), {db_out, 1'b0, toggle_out}, {1'b0, 1'b0, exp_tog});
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
